// File: rtl/exec_shift_alu_mem.sv
// rtl/exec_shift_alu_mem.sv - execute stage: ARM barrel shifter, 16-op ALU, NZCV flags, word data memory
module exec_shift_alu_mem #(
    parameter int MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Shift_Data,
    input  logic [7:0]  Shift_Num,
    input  logic [2:0]  Shift_OP,
    output logic [31:0] Shift_out,
    output logic        Shift_carry_out,
    input  logic [31:0] ALU_A,
    input  logic        ALU_B_s,
    input  logic [31:0] ALU_B,
    input  logic [3:0]  ALU_OP,
    input  logic        S,
    output logic [31:0] F,
    output logic [3:0]  NZCV_next,
    output logic [3:0]  NZCV,
    input  logic        mem_write,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_w_data,
    output logic [31:0] m_r_data
);

    localparam int AW = $clog2(MEM_DEPTH);

    // Shifter building blocks, all using the low five amount bits.
    logic [4:0]  n5;
    logic [4:0]  n5_m1;
    logic [4:0]  lsl_idx;
    logic [31:0] lsl_v;
    logic [31:0] lsr_v;
    logic [31:0] asr_v;
    logic [63:0] ror_full;
    logic        sign;
    logic        reg_zero;
    logic        reg_lt32;
    logic        reg_eq32;

    assign n5       = Shift_Num[4:0];
    assign n5_m1    = n5 - 5'd1;
    assign lsl_idx  = 5'd0 - n5;               // 32 - n for n in 1..31: last bit shifted out on LSL
    assign lsl_v    = Shift_Data << n5;
    assign lsr_v    = Shift_Data >> n5;
    assign asr_v    = 32'($signed(Shift_Data) >>> n5);
    assign ror_full = {Shift_Data, Shift_Data} >> n5;
    assign sign     = Shift_Data[31];
    assign reg_zero = (Shift_Num == 8'd0);
    assign reg_lt32 = (Shift_Num < 8'd32);
    assign reg_eq32 = (Shift_Num == 8'd32);

    // Barrel shifter: immediate forms reinterpret amount 0, register forms saturate past 31.
    always_comb begin
        Shift_out       = Shift_Data;
        Shift_carry_out = NZCV[1];
        case (Shift_OP)
            3'b000: begin
                if (n5 != 5'd0) begin
                    Shift_out       = lsl_v;
                    Shift_carry_out = Shift_Data[lsl_idx];
                end
            end
            3'b001: begin
                if (!reg_zero) begin
                    if (reg_lt32) begin
                        Shift_out       = lsl_v;
                        Shift_carry_out = Shift_Data[lsl_idx];
                    end else begin
                        Shift_out       = 32'd0;
                        Shift_carry_out = reg_eq32 ? Shift_Data[0] : 1'b0;
                    end
                end
            end
            3'b010: begin
                if (n5 == 5'd0) begin
                    Shift_out       = 32'd0;
                    Shift_carry_out = sign;
                end else begin
                    Shift_out       = lsr_v;
                    Shift_carry_out = Shift_Data[n5_m1];
                end
            end
            3'b011: begin
                if (!reg_zero) begin
                    if (reg_lt32) begin
                        Shift_out       = lsr_v;
                        Shift_carry_out = Shift_Data[n5_m1];
                    end else begin
                        Shift_out       = 32'd0;
                        Shift_carry_out = reg_eq32 ? sign : 1'b0;
                    end
                end
            end
            3'b100: begin
                if (n5 == 5'd0) begin
                    Shift_out       = {32{sign}};
                    Shift_carry_out = sign;
                end else begin
                    Shift_out       = asr_v;
                    Shift_carry_out = Shift_Data[n5_m1];
                end
            end
            3'b101: begin
                if (!reg_zero) begin
                    if (reg_lt32) begin
                        Shift_out       = asr_v;
                        Shift_carry_out = Shift_Data[n5_m1];
                    end else begin
                        Shift_out       = {32{sign}};
                        Shift_carry_out = sign;
                    end
                end
            end
            3'b110: begin
                if (n5 == 5'd0) begin
                    Shift_out       = {NZCV[1], Shift_Data[31:1]};   // RRX
                    Shift_carry_out = Shift_Data[0];
                end else begin
                    Shift_out       = ror_full[31:0];
                    Shift_carry_out = Shift_Data[n5_m1];
                end
            end
            default: begin
                if (!reg_zero) begin
                    if (n5 == 5'd0) begin
                        Shift_carry_out = sign;                   // rotate by a multiple of 32
                    end else begin
                        Shift_out       = ror_full[31:0];
                        Shift_carry_out = Shift_Data[n5_m1];
                    end
                end
            end
        endcase
    end

    logic [31:0] op_b;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [32:0] sum;
    logic        is_arith;

    assign op_b = ALU_B_s ? ALU_B : Shift_out;
    assign sum  = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

    // Adder operand steering: every subtract is folded into x + ~y + carry-in.
    always_comb begin
        add_x    = ALU_A;
        add_y    = op_b;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (ALU_OP)
            4'h2, 4'hA: begin add_y = ~op_b; add_cin = 1'b1; end
            4'h3:       begin add_x = op_b; add_y = ~ALU_A; add_cin = 1'b1; end
            4'h4, 4'hB: begin add_cin = 1'b0; end
            4'h5:       begin add_cin = NZCV[1]; end
            4'h6:       begin add_y = ~op_b; add_cin = NZCV[1]; end
            4'h7:       begin add_x = op_b; add_y = ~ALU_A; add_cin = NZCV[1]; end
            default:    begin is_arith = 1'b0; end
        endcase
    end

    // ALU result and the flags it would produce; logical ops take C from the shifter and keep V.
    always_comb begin
        case (ALU_OP)
            4'h0, 4'h8: F = ALU_A & op_b;
            4'h1, 4'h9: F = ALU_A ^ op_b;
            4'hC:       F = ALU_A | op_b;
            4'hD:       F = op_b;
            4'hE:       F = ALU_A & ~op_b;
            4'hF:       F = ~op_b;
            default:    F = sum[31:0];
        endcase
        NZCV_next[3] = F[31];
        NZCV_next[2] = (F == 32'd0);
        if (is_arith) begin
            NZCV_next[1] = sum[32];
            NZCV_next[0] = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
        end else begin
            NZCV_next[1] = Shift_carry_out;
            NZCV_next[0] = NZCV[0];
        end
    end

    // Architectural flag register, loaded only when S is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            NZCV <= 4'd0;
        end else if (S) begin
            NZCV <= NZCV_next;
        end
    end

    logic [31:0] mem [MEM_DEPTH];
    logic        unused_addr;

    assign unused_addr = ^{m_addr[31:AW+2], m_addr[1:0]};
    assign m_r_data    = mem[m_addr[AW+1:2]];

    // Word memory: reset clears every word and overrides a same-edge write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (mem_write) begin
            mem[m_addr[AW+1:2]] <= m_w_data;
        end
    end

endmodule

// File: tb/tb_exec_shift_alu_mem.sv
// tb/tb_exec_shift_alu_mem.sv - directed and randomized check of exec_shift_alu_mem against a reference model
module tb_exec_shift_alu_mem;

    logic        clk;
    logic        rst;
    logic [31:0] Shift_Data;
    logic [7:0]  Shift_Num;
    logic [2:0]  Shift_OP;
    logic [31:0] Shift_out;
    logic        Shift_carry_out;
    logic [31:0] ALU_A;
    logic        ALU_B_s;
    logic [31:0] ALU_B;
    logic [3:0]  ALU_OP;
    logic        S;
    logic [31:0] F;
    logic [3:0]  NZCV_next;
    logic [3:0]  NZCV;
    logic        mem_write;
    logic [31:0] m_addr;
    logic [31:0] m_w_data;
    logic [31:0] m_r_data;

    int total = 0;
    int bad   = 0;

    logic [3:0]  exp_nzcv;
    logic [31:0] mem_model [64];

    exec_shift_alu_mem #(.MEM_DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .Shift_Data(Shift_Data), .Shift_Num(Shift_Num), .Shift_OP(Shift_OP),
        .Shift_out(Shift_out), .Shift_carry_out(Shift_carry_out),
        .ALU_A(ALU_A), .ALU_B_s(ALU_B_s), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .S(S),
        .F(F), .NZCV_next(NZCV_next), .NZCV(NZCV),
        .mem_write(mem_write), .m_addr(m_addr), .m_w_data(m_w_data), .m_r_data(m_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Shifter reference: shifts done on 64-bit words, rotates one bit at a time.
    function automatic void model_shift(input logic [31:0] d, input logic [7:0] n, input logic [2:0] op,
                                        input logic c, output logic [31:0] o, output logic co);
        int k;
        int kind;
        logic [63:0] v;
        logic signed [63:0] sv;
        int n5;
        n5 = int'(n[4:0]);
        o  = d;
        co = c;
        case (op)
            3'd0: begin k = n5; kind = 0; end
            3'd1: begin k = int'(n); kind = 0; end
            3'd2: begin k = (n5 == 0) ? 32 : n5; kind = 1; end
            3'd3: begin k = int'(n); kind = 1; end
            3'd4: begin k = (n5 == 0) ? 32 : n5; kind = 2; end
            3'd5: begin k = int'(n); kind = 2; end
            3'd6: begin k = n5; kind = 3; end
            default: begin k = int'(n); kind = 3; end
        endcase
        if (op == 3'd6 && n5 == 0) begin
            o  = {c, d[31:1]};
            co = d[0];
        end else if (k != 0) begin
            case (kind)
                0: begin
                    v  = (k >= 64) ? 64'd0 : ({32'd0, d} << k);
                    o  = v[31:0];
                    co = v[32];
                end
                1: begin
                    v  = (k >= 64) ? 64'd0 : ({d, 32'd0} >> k);
                    o  = v[63:32];
                    co = v[31];
                end
                2: begin
                    sv = {d, 32'd0};
                    sv = sv >>> ((k > 63) ? 63 : k);
                    o  = sv[63:32];
                    co = sv[31];
                end
                default: begin
                    for (int i = 0; i < k; i++) begin
                        co = o[0];
                        o  = {o[0], o[31:1]};
                    end
                end
            endcase
        end
    endfunction

    // ALU reference: arithmetic in signed/unsigned 64-bit integers, flags from range checks.
    function automatic void model_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                      input logic [3:0] nz, input logic sc,
                                      output logic [31:0] f, output logic [3:0] fl);
        logic [31:0] p, q;
        longint pu, qu, sp, sq, e, tot, st;
        int mode;   // 0 logical, 1 add, 2 subtract
        logic cf, vf;
        p = a; q = b; e = 0; mode = 0;
        case (op)
            4'h2, 4'hA: begin mode = 2; end
            4'h3:       begin mode = 2; p = b; q = a; end
            4'h4, 4'hB: begin mode = 1; end
            4'h5:       begin mode = 1; e = longint'(nz[1]); end
            4'h6:       begin mode = 2; e = nz[1] ? 0 : 1; end
            4'h7:       begin mode = 2; p = b; q = a; e = nz[1] ? 0 : 1; end
            default:    mode = 0;
        endcase
        pu = longint'(p);
        qu = longint'(q);
        sp = longint'($signed(p));
        sq = longint'($signed(q));
        cf = sc;
        vf = nz[0];
        f  = 32'd0;
        if (mode == 1) begin
            tot = pu + qu + e;
            f   = tot[31:0];
            cf  = (tot > 64'sd4294967295);
            st  = sp + sq + e;
            vf  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        end else if (mode == 2) begin
            tot = pu - qu - e;
            f   = tot[31:0];
            cf  = (pu >= qu + e);
            st  = sp - sq - e;
            vf  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        end else begin
            case (op)
                4'h0, 4'h8: f = a & b;
                4'h1, 4'h9: f = a ^ b;
                4'hC:       f = a | b;
                4'hD:       f = b;
                4'hE:       f = a & ~b;
                default:    f = ~b;
            endcase
        end
        fl = {f[31], f == 32'd0, cf, vf};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] m_so, m_f;
    logic        m_sc;
    logic [3:0]  m_fl;

    initial begin
        rst = 1'b1; Shift_Data = 0; Shift_Num = 0; Shift_OP = 0;
        ALU_A = 0; ALU_B_s = 0; ALU_B = 0; ALU_OP = 0; S = 0;
        mem_write = 0; m_addr = 0; m_w_data = 0;
        #1 rst = 1'b0;
        #2;
        chk("reset_nzcv", 32'(NZCV), 32'h0);
        m_addr = 32'h0; #1;
        chk("reset_mem_0", m_r_data, 32'h0);
        m_addr = 32'hFC; #1;
        chk("reset_mem_fc", m_r_data, 32'h0);
        @(negedge clk) rst = 1'b1;
        exp_nzcv = 4'h0;

        Shift_Data = 32'h80000001; Shift_Num = 8'd1; Shift_OP = 3'b000; #1;
        chk("lsl_imm_out", Shift_out, 32'h00000002);
        chk("lsl_imm_c", 32'(Shift_carry_out), 32'h1);
        Shift_Num = 8'd40; Shift_OP = 3'b001; #1;
        chk("lsl_reg40_out", Shift_out, 32'h0);
        chk("lsl_reg40_c", 32'(Shift_carry_out), 32'h0);

        ALU_A = 32'hFFFFFFFF; ALU_B = 32'd2; ALU_B_s = 1'b1; ALU_OP = 4'h4; S = 1'b1; #1;
        chk("add_carry_next", 32'(NZCV_next), 32'h2);
        tick();
        S = 1'b0;
        chk("nzcv_0010", 32'(NZCV), 32'h2);
        Shift_Data = 32'h1; Shift_Num = 8'd0; Shift_OP = 3'b110; #1;
        chk("rrx_out", Shift_out, 32'h80000000);
        chk("rrx_c", 32'(Shift_carry_out), 32'h1);

        ALU_A = 32'd5; ALU_B = 32'd5; ALU_OP = 4'h2; S = 1'b1; #1;
        chk("sub_f", F, 32'h0);
        chk("sub_next", 32'(NZCV_next), 32'h6);
        tick();
        chk("sub_nzcv", 32'(NZCV), 32'h6);
        S = 1'b0; ALU_OP = 4'h4; ALU_A = 32'd1; ALU_B = 32'd1;
        tick();
        chk("hold_nzcv", 32'(NZCV), 32'h6);

        ALU_A = 32'h7FFFFFFF; ALU_B = 32'd1; ALU_OP = 4'h4; #1;
        chk("add_ovf_f", F, 32'h80000000);
        chk("add_ovf_next", 32'(NZCV_next), 32'h9);
        ALU_B_s = 1'b0; Shift_Data = 32'h80000000; Shift_Num = 8'd1; Shift_OP = 3'b000; ALU_OP = 4'hD; #1;
        chk("mov_f", F, 32'h0);
        chk("mov_next", 32'(NZCV_next), 32'h6);
        ALU_B_s = 1'b1; ALU_OP = 4'h4; S = 1'b1;
        tick();
        S = 1'b0;
        chk("nzcv_1001", 32'(NZCV), 32'h9);
        ALU_B_s = 1'b0; ALU_OP = 4'hD; #1;
        chk("mov_keep_v", 32'(NZCV_next), 32'h7);
        exp_nzcv = 4'h9;

        m_addr = 32'h10; m_w_data = 32'hDEADBEEF; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        chk("mem_rd_10", m_r_data, 32'hDEADBEEF);
        m_addr = 32'h10 + 32'd256; #1;
        chk("mem_rd_alias", m_r_data, 32'hDEADBEEF);
        m_addr = 32'h13; #1;
        chk("mem_rd_byteoff", m_r_data, 32'hDEADBEEF);

        m_addr = 32'h20; m_w_data = 32'h12345678; mem_write = 1'b1;
        rst = 1'b0;
        tick();
        chk("rst_beats_write", m_r_data, 32'h0);
        m_addr = 32'h10; #1;
        chk("rst_clears_mem", m_r_data, 32'h0);
        chk("rst_clears_nzcv", 32'(NZCV), 32'h0);
        @(negedge clk);
        rst = 1'b1; mem_write = 1'b0;
        exp_nzcv = 4'h0;
        for (int i = 0; i < 64; i++) mem_model[i] = 32'd0;
        #1;

        for (int it = 0; it < 400; it++) begin
            Shift_Data = $urandom;
            case ($urandom_range(0, 3))
                0: Shift_Num = 8'($urandom_range(0, 31));
                1: Shift_Num = 8'($urandom_range(31, 34));
                2: Shift_Num = 8'($urandom_range(0, 1)) * 8'd64 + 8'($urandom_range(0, 1)) * 8'd32;
                default: Shift_Num = 8'($urandom);
            endcase
            Shift_OP  = 3'($urandom);
            ALU_A     = ($urandom_range(0, 5) == 0) ? 32'h7FFFFFFF : $urandom;
            ALU_B     = ($urandom_range(0, 5) == 0) ? ALU_A : $urandom;
            ALU_B_s   = 1'($urandom);
            ALU_OP    = 4'($urandom);
            S         = 1'($urandom);
            mem_write = 1'($urandom);
            m_addr    = $urandom;
            m_w_data  = $urandom;
            #1;
            model_shift(Shift_Data, Shift_Num, Shift_OP, exp_nzcv[1], m_so, m_sc);
            model_alu(ALU_A, ALU_B_s ? ALU_B : m_so, ALU_OP, exp_nzcv, m_sc, m_f, m_fl);
            chk("rnd_shift_out", Shift_out, m_so);
            chk("rnd_shift_c", 32'(Shift_carry_out), 32'(m_sc));
            chk("rnd_alu_f", F, m_f);
            chk("rnd_nzcv_next", 32'(NZCV_next), 32'(m_fl));
            chk("rnd_mem_rd", m_r_data, mem_model[m_addr[7:2]]);
            tick();
            if (S) exp_nzcv = m_fl;
            if (mem_write) mem_model[m_addr[7:2]] = m_w_data;
            chk("rnd_nzcv", 32'(NZCV), 32'(exp_nzcv));
            chk("rnd_mem_after", m_r_data, mem_model[m_addr[7:2]]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
